serial_rbs_sub: RTL and testbench

- Bit-serial ripple-borrow subtractor: computes D = A − B − Bin, one bit per clock, LSB first.
- Registered borrow and start/busy/done handshake.
- It is the subtract-side counterpart of the 4-bit ripple carry adder.
- Feeds the same 7-segment result path: difference in d, final borrow in bo.

---
 rtl/serial_rbs_sub_pkg.sv | 13 +
 rtl/full_sub.sv | 14 +
 rtl/serial_rbs_sub.sv | 121 ++++++++++++
 tb/tb_serial_rbs_sub.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/serial_rbs_sub_pkg.sv
// Shared constants for the bit-serial ripple-borrow subtractor.
package serial_rbs_sub_pkg;

  // Operand width used when the top is instantiated without an override.
  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_rbs_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// with a start/busy/done handshake.
module serial_rbs_sub
  import serial_rbs_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fs_d, fs_bo;

  full_sub u_full_sub (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // Next-state logic: accept in IDLE, one bit per cycle in RUN, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bo_d    = bo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bi;
          d_d     = '0;
          bo_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        d_d[cnt_q] = fs_d;
        brw_d      = fs_bo;
        a_sr_d     = a_sr_q >> 1;
        b_sr_d     = b_sr_q >> 1;
        if (cnt_q == LastCnt) begin
          // Counter holds at the last index; it is cleared on the next accept.
          state_d = ST_DONE;
          bo_d    = fs_bo;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_rbs_sub.sv
// Scoreboard bench for serial_rbs_sub: stimulus pushes expected {d, bo},
// a negedge monitor pops and compares whenever done is seen.
module tb_serial_rbs_sub;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;

  logic [W:0] exp_q[$];

  serial_rbs_sub #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bi      (bi),
    .d       (d),
    .bo      (bo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: counts busy cycles and scores each done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        logic [W:0] e;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("d", int'(d), int'(e[W:1]));
          check("bo", int'(bo), int'(e[0]));
          check("busy_cycles", busy_cnt, W);
          check("busy_low_at_done", int'(busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one operation and wait until the DUT is back in IDLE.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tbi, input logic [W-1:0] ed, input logic ebo);
    a     = ta;
    b     = tb_;
    bi    = tbi;
    start = 1'b1;
    exp_q.push_back({ed, ebo});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bi      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", int'(d), 0);
    check("rst_bo", int'(bo), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(4'd9,  4'd3,  1'b0, 4'h6, 1'b0);
    do_op(4'd3,  4'd9,  1'b0, 4'hA, 1'b1);
    do_op(4'd0,  4'd0,  1'b1, 4'hF, 1'b1);
    do_op(4'd15, 4'd15, 1'b0, 4'h0, 1'b0);
    do_op(4'd15, 4'd15, 1'b1, 4'hF, 1'b1);

    // Start and operands toggled throughout RUN and DONE must be ignored.
    a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;
    exp_q.push_back({4'h6, 1'b0});
    @(posedge clk); #1;
    a = 4'd0; b = 4'd15; bi = 1'b1;
    repeat (W + 1) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_ignored", int'(busy), 0);
    do_op(4'd2, 4'd1, 1'b0, 4'h1, 1'b0);

    // Reset on the second RUN cycle: outputs clear at once, no done.
    a = 4'd12; b = 4'd5; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("partial_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_d", int'(d), 0);
    check("midrst_bo", int'(bo), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    // Release with start already high: accepted on the first edge.
    start = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b1;
    exp_q.push_back({4'h7, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_after_rst", int'(busy), 1);
    repeat (W + 4) @(posedge clk);
    #1;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
